// File: rtl/cmos_capture_rgb565_pkg.sv
// Shared definitions for the CMOS RGB565 capture stage: widths, FSM encoding,
// vsync polarity constants and the pixel payload layout.
package cmos_capture_rgb565_pkg;

    localparam int unsigned RGB565_W    = 16;
    localparam int unsigned CMOS_BYTE_W = 8;
    localparam int unsigned CNT_W       = 11;
    localparam int unsigned FRAME_CNT_W = 8;
    localparam int unsigned SKIP_W      = 4;

    localparam logic VSYNC_ACTIVE_HIGH = 1'b1;
    localparam logic VSYNC_ACTIVE_LOW  = 1'b0;

    localparam logic [1:0] ST_SYNC_ENC = 2'd0;
    localparam logic [1:0] ST_SKIP_ENC = 2'd1;
    localparam logic [1:0] ST_RUN_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_SYNC = ST_SYNC_ENC,
        ST_SKIP = ST_SKIP_ENC,
        ST_RUN  = ST_RUN_ENC
    } cap_state_e;

    typedef struct packed {
        logic [CMOS_BYTE_W-1:0] hi;
        logic [CMOS_BYTE_W-1:0] lo;
    } rgb565_pair_t;

    // Saturating increment so an overlong line/frame never wraps into a false match.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cmos_capture_rgb565_if.sv
// Camera-side raw bus plus the normalized RGB565 pixel stream and status.
interface cmos_capture_rgb565_if;
    import cmos_capture_rgb565_pkg::*;

    logic                   cmos_vsync;
    logic                   cmos_href;
    logic [CMOS_BYTE_W-1:0] cmos_data;
    logic                   cmos_frame_vsync;
    logic                   cmos_frame_href;
    logic                   cmos_frame_clken;
    logic [RGB565_W-1:0]    cmos_frame_data;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   frame_error;

    modport master (
        input  cmos_vsync, cmos_href, cmos_data,
        output cmos_frame_vsync, cmos_frame_href, cmos_frame_clken, cmos_frame_data,
               frame_cnt, frame_error
    );

    modport slave (
        output cmos_vsync, cmos_href, cmos_data,
        input  cmos_frame_vsync, cmos_frame_href, cmos_frame_clken, cmos_frame_data,
               frame_cnt, frame_error
    );

endinterface

// File: rtl/cmos_capture_rgb565_frame_checker.sv
// Per-line pixel and per-frame line geometry checks, sticky error flag and
// count of frames emitted while running.
module cmos_capture_rgb565_frame_checker
    import cmos_capture_rgb565_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMG_HDISP = 11'd640,
    parameter logic [CNT_W-1:0] IMG_VDISP = 11'd480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic                   href_rise,
    input  logic                   href_fall,
    input  logic                   pixel_strobe,
    input  logic                   odd_byte,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   frame_error
);

    logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]       line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0]       line_cnt_inc_c;
    logic                   in_frame_q, in_frame_d;
    logic                   frame_error_q, frame_error_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            in_frame_q    <= 1'b0;
            frame_error_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            in_frame_q    <= in_frame_d;
            frame_error_q <= frame_error_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // A line ending on the same cycle as the frame is counted before the frame check.
    always_comb begin
        pix_cnt_d      = pix_cnt_q;
        in_frame_d     = in_frame_q;
        frame_error_d  = frame_error_q;
        frame_cnt_d    = frame_cnt_q;
        line_cnt_inc_c = href_fall ? sat_inc(line_cnt_q) : line_cnt_q;
        line_cnt_d     = frame_start ? '0 : line_cnt_inc_c;

        if (href_rise) begin
            pix_cnt_d = '0;
        end else if (pixel_strobe) begin
            pix_cnt_d = sat_inc(pix_cnt_q);
        end

        if (frame_start && run) begin
            in_frame_d = 1'b1;
        end else if (frame_end) begin
            in_frame_d = 1'b0;
        end

        if (run && odd_byte) begin
            frame_error_d = 1'b1;
        end
        if (run && href_fall && (pix_cnt_q != IMG_HDISP)) begin
            frame_error_d = 1'b1;
        end
        if (run && frame_end && in_frame_q) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            if (line_cnt_inc_c != IMG_VDISP) begin
                frame_error_d = 1'b1;
            end
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign frame_error = frame_error_q;

endmodule

// File: rtl/cmos_capture_rgb565.sv
// CMOS 8-bit bus capture: registers the raw bus, drops settling frames after
// reset and pairs bytes into RGB565 words with a one-cycle strobe.
module cmos_capture_rgb565
    import cmos_capture_rgb565_pkg::*;
#(
    parameter logic              CMOS_VSYNC_VALID   = VSYNC_ACTIVE_HIGH,
    parameter logic [SKIP_W-1:0] CMOS_FRAME_WAITCNT = 4'd10,
    parameter logic [CNT_W-1:0]  IMG_HDISP          = 11'd640,
    parameter logic [CNT_W-1:0]  IMG_VDISP          = 11'd480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cmos_capture_rgb565_if.master cam
);

    localparam logic VSYNC_IDLE = (CMOS_VSYNC_VALID == VSYNC_ACTIVE_HIGH) ?
                                  VSYNC_ACTIVE_LOW : VSYNC_ACTIVE_HIGH;

    cap_state_e             state_q, state_d;
    logic [SKIP_W-1:0]      skip_cnt_q, skip_cnt_d;
    logic                   vsync_in_q, vsync_in_d;
    logic                   href_in_q, href_in_d;
    logic [CMOS_BYTE_W-1:0] data_in_q, data_in_d;
    logic                   vs_dly_q, vs_dly_d;
    logic                   href_dly_q, href_dly_d;
    logic                   toggle_q, toggle_d;
    logic [CMOS_BYTE_W-1:0] hi_q, hi_d;
    logic                   frame_vsync_q, frame_vsync_d;
    logic                   frame_href_q, frame_href_d;
    logic                   clken_q, clken_d;
    rgb565_pair_t           pix_q, pix_d;

    logic                   vs_c, run_c, frame_start_c, frame_end_c;
    logic                   href_rise_c, href_fall_c, pair_c, odd_c;
    logic [FRAME_CNT_W-1:0] frame_cnt_w;
    logic                   frame_error_w;

    // Idle vsync resets to its inactive level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SYNC;
            skip_cnt_q    <= '0;
            vsync_in_q    <= VSYNC_IDLE;
            href_in_q     <= 1'b0;
            data_in_q     <= '0;
            vs_dly_q      <= 1'b0;
            href_dly_q    <= 1'b0;
            toggle_q      <= 1'b0;
            hi_q          <= '0;
            frame_vsync_q <= 1'b0;
            frame_href_q  <= 1'b0;
            clken_q       <= 1'b0;
            pix_q         <= '0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            vsync_in_q    <= vsync_in_d;
            href_in_q     <= href_in_d;
            data_in_q     <= data_in_d;
            vs_dly_q      <= vs_dly_d;
            href_dly_q    <= href_dly_d;
            toggle_q      <= toggle_d;
            hi_q          <= hi_d;
            frame_vsync_q <= frame_vsync_d;
            frame_href_q  <= frame_href_d;
            clken_q       <= clken_d;
            pix_q         <= pix_d;
        end
    end

    assign vs_c          = (CMOS_VSYNC_VALID == VSYNC_ACTIVE_HIGH) ? vsync_in_q : ~vsync_in_q;
    assign run_c         = (state_q == ST_RUN);
    assign frame_start_c = vs_c & ~vs_dly_q;
    assign frame_end_c   = ~vs_c & vs_dly_q;
    assign href_rise_c   = href_in_q & ~href_dly_q;
    assign href_fall_c   = ~href_in_q & href_dly_q;
    assign pair_c        = href_in_q & toggle_q;
    assign odd_c         = ~href_in_q & toggle_q;

    // RUN is only entered on a frame end, so the first emitted frame is whole.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        case (state_q)
            ST_SYNC: begin
                if (frame_end_c) begin
                    skip_cnt_d = '0;
                    state_d    = (CMOS_FRAME_WAITCNT == '0) ? ST_RUN : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (frame_end_c) begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_d == CMOS_FRAME_WAITCNT) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        vsync_in_d    = cam.cmos_vsync;
        href_in_d     = cam.cmos_href;
        data_in_d     = cam.cmos_data;
        vs_dly_d      = vs_c;
        href_dly_d    = href_in_q;
        toggle_d      = href_in_q ? ~toggle_q : 1'b0;
        hi_d          = hi_q;
        pix_d         = pix_q;
        clken_d       = 1'b0;
        frame_vsync_d = vs_c & run_c;
        frame_href_d  = href_in_q & run_c;

        if (href_in_q && !toggle_q) begin
            hi_d = data_in_q;
        end
        if (pair_c && run_c) begin
            pix_d.hi = hi_q;
            pix_d.lo = data_in_q;
            clken_d  = 1'b1;
        end
    end

    cmos_capture_rgb565_frame_checker #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_checker (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run_c),
        .frame_start  (frame_start_c),
        .frame_end    (frame_end_c),
        .href_rise    (href_rise_c),
        .href_fall    (href_fall_c),
        .pixel_strobe (clken_d),
        .odd_byte     (odd_c),
        .frame_cnt    (frame_cnt_w),
        .frame_error  (frame_error_w)
    );

    assign cam.cmos_frame_vsync = frame_vsync_q;
    assign cam.cmos_frame_href  = frame_href_q;
    assign cam.cmos_frame_clken = clken_q;
    assign cam.cmos_frame_data  = pix_q;
    assign cam.frame_cnt        = frame_cnt_w;
    assign cam.frame_error      = frame_error_w;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Bench for cmos_capture_rgb565: one instance with high vsync and two skip
// frames, one with inverted vsync and no skip, checked against a frame model.
module tb_cmos_capture_rgb565;
    import cmos_capture_rgb565_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    cmos_capture_rgb565_if bus_a ();
    cmos_capture_rgb565_if bus_b ();

    cmos_capture_rgb565 #(
        .CMOS_VSYNC_VALID   (1'b1),
        .CMOS_FRAME_WAITCNT (4'd2),
        .IMG_HDISP          (11'd8),
        .IMG_VDISP          (11'd4)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .cam   (bus_a)
    );

    cmos_capture_rgb565 #(
        .CMOS_VSYNC_VALID   (1'b0),
        .CMOS_FRAME_WAITCNT (4'd0),
        .IMG_HDISP          (11'd2),
        .IMG_VDISP          (11'd2)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .cam   (bus_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] obs_w[$];
    int          obs_c[$];
    int          align_bad = 0;
    int          vs_hi_a   = 0;
    int          href_hi_a = 0;
    int          ck_b      = 0;
    int          vs_hi_b   = 0;

    always @(negedge clk) begin
        if (bus_a.cmos_frame_clken) begin
            obs_w.push_back(bus_a.cmos_frame_data);
            obs_c.push_back(cyc);
            if (!(bus_a.cmos_frame_vsync && bus_a.cmos_frame_href)) align_bad <= align_bad + 1;
        end
        if (bus_a.cmos_frame_vsync) vs_hi_a <= vs_hi_a + 1;
        if (bus_a.cmos_frame_href)  href_hi_a <= href_hi_a + 1;
        if (bus_b.cmos_frame_clken) ck_b <= ck_b + 1;
        if (bus_b.cmos_frame_vsync) vs_hi_b <= vs_hi_b + 1;
    end

    // Model state per instance: frame ends since reset, expected frame_cnt / error.
    int fe[2];
    int exp_cnt[2];
    bit exp_err[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rb();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [31:0] outs_a();
        return 32'({bus_a.cmos_frame_vsync, bus_a.cmos_frame_href, bus_a.cmos_frame_clken,
                    bus_a.cmos_frame_data, bus_a.frame_cnt, bus_a.frame_error});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({bus_b.cmos_frame_vsync, bus_b.cmos_frame_href, bus_b.cmos_frame_clken,
                    bus_b.cmos_frame_data, bus_b.frame_cnt, bus_b.frame_error});
    endfunction

    // One bus cycle; vact is the logical frame window, mapped to each polarity.
    task automatic step(input int sel, input bit vact, input bit href, input logic [7:0] d);
        @(negedge clk);
        if (sel == 0) begin
            bus_a.cmos_vsync = vact;
            bus_a.cmos_href  = href;
            bus_a.cmos_data  = d;
        end else begin
            bus_b.cmos_vsync = ~vact;
            bus_b.cmos_href  = href;
            bus_b.cmos_data  = d;
        end
    endtask

    task automatic frame(input int sel, input int nlines, input int short_idx, input int short_len,
                         input bit rnd, input bit full_chk, input string tag);
        int lb, vd, wt, n, w, href_tot, base_w, base_vs, base_href, base_al;
        bit emit, geo_bad;
        logic [7:0]  hi, b8;
        logic [15:0] ew[$];
        int          ec[$];
        lb = (sel == 0) ? 16 : 4;
        vd = (sel == 0) ? 4 : 2;
        wt = (sel == 0) ? 2 : 0;
        emit      = (fe[sel] >= wt + 1);
        base_w    = obs_w.size();
        base_vs   = vs_hi_a;
        base_href = href_hi_a;
        base_al   = align_bad;
        href_tot  = 0;
        geo_bad   = 1'b0;
        hi        = 8'h00;
        step(sel, 1'b1, 1'b0, rb());
        step(sel, 1'b1, 1'b0, rb());
        w = 2;
        for (int l = 0; l < nlines; l++) begin
            n = (l == short_idx) ? short_len : lb;
            for (int b = 0; b < n; b++) begin
                b8 = rnd ? rb() : 8'(b + 1);
                step(sel, 1'b1, 1'b1, b8);
                if (b % 2 == 0) hi = b8;
                else begin
                    ew.push_back({hi, b8});
                    ec.push_back(cyc + 2);
                end
            end
            repeat (3) step(sel, 1'b1, 1'b0, rb());
            w += n + 3;
            href_tot += n;
            if (n != lb) geo_bad = 1'b1;
        end
        step(sel, 1'b1, 1'b0, rb());
        w++;
        if (nlines != vd) geo_bad = 1'b1;
        repeat (4) step(sel, 1'b0, 1'b0, rb());
        fe[sel]++;
        if (emit) begin
            exp_cnt[sel] = (exp_cnt[sel] + 1) % 256;
            if (geo_bad) exp_err[sel] = 1'b1;
        end else begin
            ew.delete();
            ec.delete();
            w = 0;
            href_tot = 0;
        end
        if (full_chk) begin
            check({tag, " words"}, 32'(obs_w.size() - base_w), 32'(ew.size()));
            for (int i = 0; i < ew.size() && base_w + i < obs_w.size(); i++) begin
                check($sformatf("%s word%0d", tag, i), 32'(obs_w[base_w + i]), 32'(ew[i]));
                check($sformatf("%s cyc%0d", tag, i), 32'(obs_c[base_w + i]), 32'(ec[i]));
            end
            check({tag, " vsync_cycles"}, 32'(vs_hi_a - base_vs), 32'(w));
            check({tag, " href_cycles"}, 32'(href_hi_a - base_href), 32'(href_tot));
            check({tag, " align"}, 32'(align_bad - base_al), 32'd0);
        end
        check({tag, " frame_cnt"}, 32'((sel == 0) ? bus_a.frame_cnt : bus_b.frame_cnt),
              32'(exp_cnt[sel]));
        check({tag, " frame_error"}, 32'((sel == 0) ? bus_a.frame_error : bus_b.frame_error),
              32'(exp_err[sel]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        fe      = '{0, 0};
        exp_cnt = '{0, 0};
        exp_err = '{1'b0, 1'b0};
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.cmos_vsync = 1'b0;
        bus_a.cmos_href  = 1'b0;
        bus_a.cmos_data  = 8'h00;
        bus_b.cmos_vsync = 1'b1;
        bus_b.cmos_href  = 1'b0;
        bus_b.cmos_data  = 8'h00;
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset held under random bus activity
        for (int i = 0; i < 10; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rb());
            check($sformatf("rst_hold%0d", i), outs_a(), 32'd0);
        end
        check("rst_hold_b", outs_b(), 32'd0);

        // Release mid-frame, then sync frame and two skipped frames
        step(0, 1'b1, 1'b0, rb());
        rst_a = 1'b1;
        frame(0, 2, -1, 0, 1'b1, 1'b1, "partial");
        frame(0, 4, -1, 0, 1'b1, 1'b1, "skip1");
        frame(0, 4, -1, 0, 1'b1, 1'b1, "skip2");

        // Emitted frames: counting bytes, random, odd line, good after error
        frame(0, 4, -1, 0, 1'b0, 1'b1, "first_out");
        frame(0, 4, -1, 0, 1'b1, 1'b1, "random");
        frame(0, 4, 1, 15, 1'b0, 1'b1, "odd_line");
        frame(0, 4, -1, 0, 1'b1, 1'b1, "after_err");

        // Asynchronous reset in the middle of a line
        step(0, 1'b1, 1'b0, rb());
        step(0, 1'b1, 1'b1, 8'hAA);
        #2 rst_a = 1'b0;
        #1 check("async_rst", outs_a(), 32'd0);
        fe[0]      = 0;
        exp_cnt[0] = 0;
        exp_err[0] = 1'b0;
        repeat (3) step(0, 1'b1, 1'b1, rb());
        step(0, 1'b1, 1'b0, rb());
        rst_a = 1'b1;
        frame(0, 1, -1, 0, 1'b1, 1'b1, "resync");
        frame(0, 4, -1, 0, 1'b1, 1'b1, "reskip1");
        frame(0, 4, -1, 0, 1'b1, 1'b1, "reskip2");
        frame(0, 3, -1, 0, 1'b1, 1'b1, "three_lines");

        // Inverted vsync, no skip: frame counter wrap over 257 emitted frames
        step(1, 1'b0, 1'b0, 8'h00);
        rst_b = 1'b1;
        step(1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 258; i++) begin
            frame(1, 2, -1, 0, 1'b1, 1'b0, $sformatf("b%0d", i));
        end
        check("b_clken_total", 32'(ck_b), 32'(257 * 4));
        check("b_vsync_cycles", 32'(vs_hi_b), 32'(257 * 17));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmos_capture_rgb565.md
Name: cmos_capture_rgb565

Overview:
- Camera-side capture stage that consumes the raw 8-bit CMOS bus (pclk/vsync/href/data) and produces 16-bit RGB565 pixels with a one-cycle valid strobe.
- Discards a programmable number of frames after reset so sensor register settings can settle.
- Guarantees the first emitted frame is complete.
- Sits between the CMOS camera interface (or its simulation model) and the image-processing pipeline (e.g. the median filter).

Parameters:
CMOS_VSYNC_VALID, 1'b1, 1: vsync high = frame data window; 0: vsync low = frame data window
CMOS_FRAME_WAITCNT, 4'd10, number of complete frames dropped after sync before output is enabled (0 allowed)
IMG_HDISP, 11'd640, expected pixels (byte pairs) per line
IMG_VDISP, 11'd480, expected lines per frame

Ports:
clk  input  1  cmos_pclk; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmos_vsync  input  1  raw frame sync, polarity per CMOS_VSYNC_VALID
cmos_href  input  1  line valid, active high
cmos_data  input  8  raw byte, high byte first per pixel
cmos_frame_vsync  output  1  normalized frame window, active high, gated by RUN
cmos_frame_href  output  1  line valid, aligned with data, gated by RUN
cmos_frame_clken  output  1  one-cycle strobe per RGB565 pixel
cmos_frame_data  output  16  RGB565 pixel {first byte, second byte}
frame_cnt  output  8  count of frames emitted in RUN, wraps 255->0
frame_error  output  1  sticky geometry/odd-byte error flag

Behaviour:
- Reset values: all outputs 0, state SYNC, byte toggle 0, all counters 0.
- Input stage: vsync, href and data registered once. Normalize vs = CMOS_VSYNC_VALID ? vsync_r : ~vsync_r. Keep a 1-cycle-delayed copy for edge detection.
- frame_start = rising edge of vs; frame_end = falling edge of vs.
- States:
  - SYNC: wait for frame_end, then go to SKIP (WAITCNT>0) or RUN (WAITCNT==0).
  - SKIP: count frame_end events; go to RUN on the WAITCNT-th one.
  - RUN: terminal until reset.
  - Entering RUN on a frame_end means output starts at the next frame_start, so no partial frame is ever emitted.
- Byte pairing: toggle clears whenever href_r=0; it flips on each href_r=1 cycle.
  - toggle=0: latch byte into hi.
  - toggle=1: cmos_frame_data <= {hi, byte} and clken <= 1 (RUN only). Otherwise clken <= 0.
- Latency: a second byte present on cmos_data at edge k appears on cmos_frame_data/clken after edge k+1.
- cmos_frame_vsync and cmos_frame_href are vs and href_r delayed one further cycle, ANDed with RUN. This aligns them with clken.
- Odd byte count: if href falls with toggle=1, the dangling byte is dropped, no clken is issued, and frame_error is set.
- Geometry check (RUN only):
  - The pixel counter clears on href rise and increments per clken. On href fall, count != IMG_HDISP sets frame_error.
  - The line counter clears on frame_start and increments per href fall. On frame_end, count != IMG_VDISP sets frame_error.
- frame_cnt: increments on each frame_end in RUN where the frame was output (i.e. a frame_start was seen in RUN); wraps modulo 256.
- frame_error is sticky, cleared only by rst_n.
- Simultaneous events: a frame_end coinciding with href fall processes the line check first; both checks may set the error in the same cycle.
- Reset mid-operation: immediate return to reset values. The block must re-sync on a full frame_end and re-skip CMOS_FRAME_WAITCNT frames.
- Widths: counters are 11 bits and saturate at 2047 (no wrap, avoids false match). The skip counter is 4 bits.

Decomposition:
- Shared camera package holds:
  - state encodings SYNC/SKIP/RUN as localparams;
  - VSYNC polarity constants;
  - RGB565 width constant (16).
- One natural sub-module: cmos_frame_checker (pixel/line counters, error flag, frame_cnt). Byte pairing and the FSM stay in the top.

Test Plan:
- Reset held, random bus activity -> all outputs 0; release mid-frame -> no clken until after the first frame_end plus the skip frames.
- CMOS_FRAME_WAITCNT=2, IMG_HDISP=8, IMG_VDISP=4, 16 bytes/line, 4 lines/frame, vsync polarity 1 -> zero clken in the first partial frame plus 2 full frames. Third frame gives exactly 32 clken, cmos_frame_vsync/href high only in that frame, frame_cnt=1, frame_error=0.
- Line bytes 0x01..0x10 -> words 0x0102, 0x0304, ..., 0x0F10 in order. Each clken occurs 2 edges after its second byte is driven.
- One line with 15 bytes -> 7 words for that line, trailing 0x0F dropped, frame_error=1 and stays 1 through later good frames.
- CMOS_VSYNC_VALID=0 with inverted vsync, WAITCNT=0 -> output from the first complete frame; 257 frames -> frame_cnt sequence ends 0xFF, 0x00, 0x01.
- A frame with 3 lines (IMG_VDISP=4) -> frame_error set at that frame_end. Assert rst_n low mid-line -> outputs 0 asynchronously, and capture resumes only after re-sync.
